// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: walks a single low column, synchronizes the rows and
// debounces both press and release, emitting one key_valid pulse per accepted key.
module keypad_scan_debounce #(
    parameter int SCAN_DIV        = 1200,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad_rows,
    output logic [3:0] keypad_cols,
    output logic [3:0] key_code,
    output logic       key_pressed,
    output logic       key_valid
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_DIV) ? DEBOUNCE_CYCLES : SCAN_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [1:0]       col_q;
    logic [1:0]       row_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       rows_meta_q;
    logic [3:0]       rows_s_q;
    logic [3:0]       key_code_q;
    logic             key_pressed_q;
    logic             key_valid_q;

    logic [3:0]       rows_low;
    logic [3:0]       held_pattern;
    logic             single_low;
    logic [1:0]       low_row;

    // Exactly one row low is a clean single key; anything else is idle or a ghost.
    always_comb begin
        rows_low     = ~rows_s_q;
        single_low   = (rows_low != 4'd0) && ((rows_low & (rows_low - 4'd1)) == 4'd0);
        held_pattern = ~(4'b0001 << row_q);
        low_row      = 2'd0;
        case (rows_low)
            4'b0010: low_row = 2'd1;
            4'b0100: low_row = 2'd2;
            4'b1000: low_row = 2'd3;
            default: low_row = 2'd0;
        endcase
    end

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_SCAN;
            col_q         <= 2'd0;
            row_q         <= 2'd0;
            cnt_q         <= '0;
            rows_meta_q   <= 4'hF;
            rows_s_q      <= 4'hF;
            key_code_q    <= 4'h0;
            key_pressed_q <= 1'b0;
            key_valid_q   <= 1'b0;
        end else begin
            rows_meta_q <= keypad_rows;
            rows_s_q    <= rows_meta_q;
            key_valid_q <= 1'b0;
            case (state_q)
                ST_SCAN: begin
                    // The dwell length absorbs synchronizer latency after a column change.
                    if (cnt_q == SCAN_LAST) begin
                        cnt_q <= '0;
                        if (single_low) begin
                            row_q   <= low_row;
                            state_q <= ST_DEBOUNCE;
                        end else begin
                            col_q <= col_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_s_q != held_pattern) begin
                        cnt_q   <= '0;
                        state_q <= ST_SCAN;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q         <= '0;
                        state_q       <= ST_HELD;
                        key_code_q    <= key_map(row_q, col_q);
                        key_valid_q   <= 1'b1;
                        key_pressed_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (rows_s_q[row_q]) begin
                        cnt_q   <= '0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // A low blip here is release bounce: resume holding without a new pulse.
                    if (!rows_s_q[row_q]) begin
                        cnt_q   <= '0;
                        state_q <= ST_HELD;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_q         <= '0;
                        state_q       <= ST_SCAN;
                        key_pressed_q <= 1'b0;
                        col_q         <= col_q + 2'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_SCAN;
                end
            endcase
        end
    end

    assign keypad_cols = ~(4'b0001 << col_q);
    assign key_code    = key_code_q;
    assign key_pressed = key_pressed_q;
    assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce: a behavioural 4x4 switch matrix drives the
// rows from the scanned columns and a set of pressed keys.
module tb_keypad_scan_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] keypad_rows;
    logic [3:0] keypad_cols;
    logic [3:0] key_code;
    logic       key_pressed;
    logic       key_valid;

    logic [15:0] press_mask;   // bit r*4+c closes the switch at row r, column c
    int          n_checks;
    int          n_errors;
    int          vcnt;
    logic        prev_valid;

    keypad_scan_debounce #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keypad_rows (keypad_rows),
        .keypad_cols (keypad_cols),
        .key_code    (key_code),
        .key_pressed (key_pressed),
        .key_valid   (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        keypad_rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press_mask[r*4+c] && !keypad_cols[c]) keypad_rows[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: counts key_valid pulses and checks each lasts exactly one cycle.
    initial begin
        vcnt       = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                vcnt++;
                chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            end
            prev_valid = key_valid;
        end
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_release(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (key_pressed === 1'b0) ok = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         v0;
        logic [3:0] exp_cols;
        logic [3:0] seen_cols;
        logic       saw_pressed;

        n_checks   = 0;
        n_errors   = 0;
        press_mask = 16'h0000;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cols", {28'd0, keypad_cols}, 32'hE);
        chk("rst_code", {28'd0, key_code}, 32'h0);
        chk("rst_pressed", {31'd0, key_pressed}, 32'd0);
        chk("rst_valid", {31'd0, key_valid}, 32'd0);

        // Idle scan: each column low for 4 clocks, wrapping back to column 0.
        reset = 1'b1;
        chk("idle_cols_0", {28'd0, keypad_cols}, 32'hE);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp_cols = ~(4'b0001 << ((i / 4) % 4));
            chk("idle_cols", {28'd0, keypad_cols}, {28'd0, exp_cols});
        end
        chk("idle_no_valid", vcnt, 0);
        chk("idle_code", {28'd0, key_code}, 32'h0);

        // Key 6 (row1/col2) held steady.
        v0 = vcnt;
        press_mask[6] = 1'b1;
        wait_valid(60, ok);
        chk("k6_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        chk("k6_code", {28'd0, key_code}, 32'h6);
        chk("k6_pressed", {31'd0, key_pressed}, 32'd1);
        chk("k6_cols", {28'd0, keypad_cols}, 32'hB);
        chk("k6_one_pulse", vcnt - v0, 1);
        repeat (20) @(negedge clk);
        chk("k6_hold_cols", {28'd0, keypad_cols}, 32'hB);
        chk("k6_hold_pulses", vcnt - v0, 1);
        press_mask[6] = 1'b0;
        repeat (10) @(negedge clk);
        chk("k6_rel_still_pressed", {31'd0, key_pressed}, 32'd1);
        chk("k6_rel_cols_held", {28'd0, keypad_cols}, 32'hB);
        @(negedge clk);
        chk("k6_rel_dropped", {31'd0, key_pressed}, 32'd0);
        chk("k6_rel_next_col", {28'd0, keypad_cols}, 32'h7);

        // Key A (row0/col3) with press bounce.
        v0 = vcnt;
        for (int k = 0; k < 3; k++) begin
            press_mask[3] = 1'b1;
            repeat (2) @(negedge clk);
            press_mask[3] = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("kA_bounce_no_pulse", vcnt - v0, 0);
        press_mask[3] = 1'b1;
        wait_valid(60, ok);
        chk("kA_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        chk("kA_code", {28'd0, key_code}, 32'hA);
        chk("kA_one_pulse", vcnt - v0, 1);
        press_mask[3] = 1'b0;
        wait_release(40, ok);
        chk("kA_released", {31'd0, ok}, 32'd1);
        chk("kA_no_second", vcnt - v0, 1);

        // Ghost: keys 1 and 7 (rows 0 and 2, col0) together are rejected.
        v0          = vcnt;
        seen_cols   = 4'h0;
        saw_pressed = 1'b0;
        press_mask  = 16'h0101;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            seen_cols   = seen_cols | ~keypad_cols;
            saw_pressed = saw_pressed | key_pressed;
        end
        chk("ghost_no_pulse", vcnt - v0, 0);
        chk("ghost_code_kept", {28'd0, key_code}, 32'hA);
        chk("ghost_all_cols", {28'd0, seen_cols}, 32'hF);
        chk("ghost_never_pressed", {31'd0, saw_pressed}, 32'd0);
        press_mask = 16'h0000;
        repeat (4) @(negedge clk);

        // Key 0 (row3/col1) with release bounce.
        v0 = vcnt;
        press_mask[13] = 1'b1;
        wait_valid(60, ok);
        chk("k0_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        chk("k0_code", {28'd0, key_code}, 32'h0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            press_mask[13] = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("k0_bounce_pressed", {31'd0, key_pressed}, 32'd1);
            end
            press_mask[13] = 1'b1;
            repeat (3) begin
                @(negedge clk);
                chk("k0_bounce_pressed", {31'd0, key_pressed}, 32'd1);
            end
        end
        press_mask[13] = 1'b0;
        repeat (9) @(negedge clk);
        chk("k0_rel_still_pressed", {31'd0, key_pressed}, 32'd1);
        wait_release(10, ok);
        chk("k0_released", {31'd0, ok}, 32'd1);
        chk("k0_one_pulse", vcnt - v0, 1);
        chk("k0_code_after", {28'd0, key_code}, 32'h0);

        // Key F (row3/col2) interrupted by reset while held.
        press_mask[14] = 1'b1;
        wait_valid(60, ok);
        chk("kF_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        chk("kF_code", {28'd0, key_code}, 32'hF);
        chk("kF_pressed", {31'd0, key_pressed}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("kF_rst_cols", {28'd0, keypad_cols}, 32'hE);
        chk("kF_rst_pressed", {31'd0, key_pressed}, 32'd0);
        chk("kF_rst_valid", {31'd0, key_valid}, 32'd0);
        chk("kF_rst_code", {28'd0, key_code}, 32'h0);
        press_mask = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        v0 = vcnt;
        repeat (30) @(negedge clk);
        chk("post_rst_no_pulse", vcnt - v0, 0);
        chk("post_rst_code", {28'd0, key_code}, 32'h0);
        chk("post_rst_pressed", {31'd0, key_pressed}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
Scans a 4x4 matrix keypad and debounces key presses. Drives one column low at a time and samples the active-low rows through a synchronizer. Emits exactly one key_valid pulse and a hex key_code for each debounced press. Sits directly upstream of the keypad controller, which consumes key_code and key_valid to update the two displayed digits.

Parameters:
SCAN_DIV, 1200, clk cycles each column is driven before rows are evaluated (100 us at 12 MHz); must be >= 4.
DEBOUNCE_CYCLES, 240000, clk cycles a pattern must stay stable to accept a press or a release (20 ms at 12 MHz); must be >= 2.

Ports:
clk  input  1  system clock, 12 MHz.
reset  input  1  asynchronous, active-low reset.
keypad_rows  input  4  row lines, active-low, externally pulled up, asynchronous to clk.
keypad_cols  output  4  column drive, active-low, exactly one bit low at all times.
key_code  output  4  hex value of the last accepted key; holds until the next accepted key.
key_pressed  output  1  high while a debounced key is held (HELD and RELEASE states).
key_valid  output  1  single-cycle pulse when a new key is accepted.

Behaviour:
- Reset (reset low, asynchronous): state=SCAN, col index=0, keypad_cols=4'b1110, key_code=0, key_pressed=0, key_valid=0, all counters=0.
- Rows pass through a 2-FF synchronizer, giving rows_s. All decisions use rows_s only.
- Column c drives keypad_cols[c] low. Row r means keypad_rows[r] low.
- Key map (row r, col c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- SCAN:
  - Dwell counter counts 0..SCAN_DIV-1. Rows are evaluated only at SCAN_DIV-1, which covers synchronizer latency.
  - Exactly one rows_s bit low: latch r and c, clear the counter, go to DEBOUNCE. The column is held.
  - All high, or two or more bits low (ghost/multi-key): advance c (3 wraps to 0), restart the dwell.
- DEBOUNCE:
  - Each cycle, compare rows_s with the latched single-low pattern.
  - Mismatch: go to SCAN on the same column, restart the dwell.
  - Match with counter = DEBOUNCE_CYCLES-1: go to HELD. On the same edge, key_code updates to map(r,c) and key_valid asserts.
- HELD:
  - key_valid is high only in the first HELD cycle, then low.
  - key_pressed=1. The column stays fixed and other keys are ignored.
  - rows_s[r] high: clear the counter, go to RELEASE.
- RELEASE:
  - key_pressed stays 1.
  - rows_s[r] low again: go to HELD without a new key_valid (bounce on release).
  - rows_s[r] high with counter = DEBOUNCE_CYCLES-1: go to SCAN, key_pressed=0, advance c.
- Latency: a clean press is seen at the end of a dwell. key_valid follows DEBOUNCE_CYCLES cycles later.
- key_valid and key_pressed are registered. key_code changes only together with a key_valid pulse.
- key_valid is never asserted twice for one physical press, however long it is held.
- If reset asserts mid-operation, all state returns to reset values immediately. No pulse is emitted on reset release.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset then idle, rows=4'b1111 -> keypad_cols cycles 1110, 1101, 1011, 0111, 1110, each for 4 clks. key_valid never asserts. key_code=0.
- Hold row1 low while col2 is active, steady for 20 clks -> exactly one key_valid pulse. key_code=4'h6. key_pressed=1. keypad_cols stays 1011 until release plus 8 stable clks.
- Press row0/col3 with 3 toggles of 2 clks each before it settles -> no pulse during bounce. One pulse after 8 stable clks with key_code=4'hA.
- Hold row3/col1 (key 0), then bounce the release 2 times, then release for good -> one key_valid with key_code=0. key_pressed drops only after 8 continuous high clks. No second pulse.
- Two rows (r0, r2) low in col0 at the same time -> no key_valid. Scan continues past col0. key_code keeps its previous value.
- Assert reset while in HELD (key F, r3/c2) -> keypad_cols=1110, key_pressed=0, key_valid=0, key_code=0 within the same cycle. No pulse after reset release while rows stay high.
